// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front end for the ALU control decoder / datapath. Accepts one command per
//   handshake, drives the function select and operands into the ALU, and
//   captures the result and carry. Multi-bit shifts are built by iterating the
//   ALU's single-bit shift, feeding each result back as operand A.
// Ports
//   clk, rst_n                   : clock, async active-low reset
//   cmd_valid/ready, cmd_op/a/b/amt : command handshake and fields
//   fs, alu_a, alu_b             : ALU function select and operands
//   alu_result, alu_carry        : combinational ALU outputs
//   res_valid/ready, res_data/carry/err : result handshake and payload
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_amt,
  output logic [2:0]       fs,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, err_q;

  logic cmd_shift, cmd_ill, cmd_zero_shift, accept;

  assign cmd_shift      = (cmd_op == OP_SRA) || (cmd_op == OP_SRL) || (cmd_op == OP_SLL);
  assign cmd_ill        = (cmd_op == OP_ILL);
  assign cmd_zero_shift = cmd_shift && (cmd_amt == '0);
  assign accept         = (state_q == IDLE) && cmd_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd_ill || cmd_zero_shift) state_d = DONE;
        else if (cmd_shift)            state_d = SHIFT;
        else                           state_d = EXEC;
      end
      EXEC:  state_d = DONE;
      // cnt_q holds the remaining shift steps including the current one
      SHIFT: if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:  if (res_ready) state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == DONE);
    fs        = 3'b000;
    if (state_q == EXEC || state_q == SHIFT) fs = op_q;
  end

  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign res_data  = acc_q;
  assign res_carry = carry_q;
  assign res_err   = err_q;

  // datapath registers; ALU output is only captured in EXEC/SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op;
      b_q   <= cmd_b;
      cnt_q <= cmd_amt;
      err_q <= cmd_ill;
      acc_q <= cmd_ill ? '0 : cmd_a;
      if (cmd_ill || cmd_zero_shift) carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      acc_q   <= alu_result;
      carry_q <= alu_carry;
    end else if (state_q == SHIFT) begin
      acc_q   <= alu_result;
      carry_q <= alu_carry;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [CNT_W-1:0] cmd_amt;
  logic [2:0]       fs;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_carry;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry, res_err;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_amt(cmd_amt),
    .fs(fs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err)
  );

  // single-step ALU model: {carry, result}
  function automatic logic [8:0] alu_step(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {a[0], a[7], a[7:1]};
      3'b011:  return {a[0], 1'b0, a[7:1]};
      3'b100:  return {a[7], a[6:0], 1'b0};
      3'b101:  return {1'b0, a & b};
      3'b110:  return {1'b0, a | b};
      default: return 9'h0;
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_step(fs, alu_a, alu_b);

  // reference for a whole command
  function automatic exp_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [2:0] amt);
    exp_t e;
    logic [8:0] r;
    e.data = a; e.carry = 1'b0; e.err = 1'b0;
    if (op == 3'b111) begin
      e.data = 8'h00; e.err = 1'b1;
    end else if (op == 3'b010 || op == 3'b011 || op == 3'b100) begin
      for (int i = 0; i < int'(amt); i++) begin
        r = alu_step(op, e.data, b);
        e.data = r[7:0]; e.carry = r[8];
      end
    end else begin
      r = alu_step(op, a, b);
      e.data = r[7:0]; e.carry = r[8];
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [2:0] amt);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_amt = amt;
    sb.push_back(model(op, a, b, amt));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_result(string tag);
    exp_t e;
    int   n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"},  32'(res_data),  32'(e.data));
      check({tag, "_carry"}, 32'(res_carry), 32'(e.carry));
      check({tag, "_err"},   32'(res_err),   32'(e.err));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  logic [7:0] sra_seq [3];

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_amt = '0; res_ready = 1'b0;
    sra_seq[0] = 8'h81; sra_seq[1] = 8'hC0; sra_seq[2] = 8'hE0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_fs",        32'(fs),        32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    rst_n = 1'b1;
    tick();

    // ADD 0xF0 + 0x20: one EXEC cycle
    send(3'b000, 8'hF0, 8'h20, 3'd0);
    check("add_fs",    32'(fs),        32'd0);
    check("add_alu_a", 32'(alu_a),     32'hF0);
    check("add_alu_b", 32'(alu_b),     32'h20);
    check("add_ready", 32'(cmd_ready), 32'd0);
    check("add_valid_exec", 32'(res_valid), 32'd0);
    tick();
    take_result("add");

    // SUB 0x10 - 0x20
    send(3'b001, 8'h10, 8'h20, 3'd0);
    check("sub_fs", 32'(fs), 32'd1);
    tick();
    take_result("sub");

    // SRA 0x81 by 3
    send(3'b010, 8'h81, 8'h00, 3'd3);
    for (int i = 0; i < 3; i++) begin
      check("sra_fs",    32'(fs),        32'd2);
      check("sra_alu_a", 32'(alu_a),     32'(sra_seq[i]));
      check("sra_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    take_result("sra");

    // SLL 0x5A by 0: valid right after accept, ALU never used
    send(3'b100, 8'h5A, 8'h00, 3'd0);
    check("sll0_fs",    32'(fs),        32'd0);
    check("sll0_valid", 32'(res_valid), 32'd1);
    take_result("sll0");

    // SLL 0x5A by 7
    send(3'b100, 8'h5A, 8'h00, 3'd7);
    take_result("sll7");

    // backpressure: OR result held while a second command waits
    send(3'b110, 8'h0F, 8'h30, 3'd0);
    tick();
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h01; cmd_b = 8'h02; cmd_amt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data",  32'(res_data),  32'h3F);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      check("bp_fs",    32'(fs),        32'd0);
      tick();
    end
    take_result("bp_or");
    // second command still held upstream; accepted now
    check("bp2_ready", 32'(cmd_ready), 32'd1);
    sb.push_back(model(3'b000, 8'h01, 8'h02, 3'd0));
    tick();
    cmd_valid = 1'b0;
    take_result("bp_add");

    // illegal op then a legal op clears res_err
    send(3'b111, 8'hFF, 8'h00, 3'd0);
    check("ill_valid", 32'(res_valid), 32'd1);
    take_result("ill");
    send(3'b101, 8'hF3, 8'h3C, 3'd0);
    take_result("and_after_ill");

    // reset mid-shift: SRL by 7, assert reset in shift cycle 3
    send(3'b011, 8'h80, 8'h00, 3'd7);
    tick(); tick();
    check("srl_fs_c3", 32'(fs), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mrst_fs",        32'(fs),        32'd0);
    check("mrst_alu_a",     32'(alu_a),     32'd0);
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    send(3'b000, 8'h01, 8'h01, 3'd0);
    tick();
    take_result("post_rst_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end stage directly upstream of the ALU control decoder and datapath.
- Accepts one ALU command per handshake, drives the 3-bit function select (FS) and operands into the ALU, and captures the result and carry.
- Performs multi-bit shifts by iterating the ALU's single-bit shift, feeding each result back as operand A.
- Presents the final result on a valid/ready output port.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- CNT_W, 3, width of shift-amount field; maximum shift is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  FS encoding: 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 illegal.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_amt  input  CNT_W  shift count; used only for ops 010/011/100.
- fs  output  3  function select to ALU control.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_result  input  WIDTH  combinational ALU result.
- alu_carry  input  1  combinational ALU carry/shift-out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  captured result.
- res_carry  output  1  captured carry.
- res_err  output  1  result came from illegal op.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (async assert, sync-released use): state=IDLE; op_reg, acc_reg, b_reg, cnt_reg, res_carry, res_err all 0.
  - Consequences: fs=000, alu_a=0, alu_b=0, res_valid=0, res_data=0, cmd_ready=1.
  - Assertion mid-operation aborts immediately; the in-flight command and any pending result are discarded.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, fs=000.
  - On cmd_valid=1: latch op_reg=cmd_op, acc_reg=cmd_a, b_reg=cmd_b, cnt_reg=cmd_amt, and clear res_err. Next state:
    - op 111: acc_reg=0, res_carry=0, res_err=1 -> DONE.
    - shift op with cmd_amt=0: acc_reg=cmd_a, res_carry=0 -> DONE.
    - shift op with cmd_amt>0 -> SHIFT.
    - any other op -> EXEC.
- EXEC:
  - Exactly one cycle; fs=op_reg, alu_a=acc_reg, alu_b=b_reg.
  - At the edge: acc_reg<=alu_result, res_carry<=alu_carry -> DONE.
- SHIFT:
  - fs=op_reg, alu_a=acc_reg, alu_b=b_reg (ignored by ALU).
  - Each edge: acc_reg<=alu_result, res_carry<=alu_carry, cnt_reg<=cnt_reg-1.
  - Exit to DONE on the edge where cnt_reg==1. Total SHIFT cycles = cmd_amt.
  - res_carry therefore holds the last bit shifted out.
- DONE:
  - res_valid=1, res_data=acc_reg, fs=000.
  - Outputs held stable until res_valid&&res_ready, then -> IDLE.
  - Result is accepted on the same edge res_ready is seen; no bubble beyond the IDLE cycle.
- cmd_ready=0 in EXEC, SHIFT and DONE. cmd_valid in those states is ignored and the command is not latched; the upstream must hold it.
- Outside EXEC/SHIFT, fs=000 and alu_a/alu_b show register contents. The ALU output is don't-care there and is never captured.
- Latency, counted from the accept edge to res_valid high:
  - non-shift legal op: 1 cycle;
  - shift: cmd_amt cycles;
  - amt=0 or illegal: 0 cycles (valid right after the accept edge).
- Arithmetic: no width growth; all registers WIDTH bits. cnt_reg decrements only in SHIFT and never wraps below 1 there.
- Throughput: one command per (latency + 2) cycles minimum. There is no overlap between result hold and the next command.

Test Plan (bench models the ALU: 8-bit add/sub with carry, single-bit shifts with carry = bit shifted out):
- ADD a=0xF0 b=0x20 -> one EXEC cycle with fs=000, alu_a=0xF0, alu_b=0x20; then res_valid=1, res_data=0x10, res_carry=1, res_err=0.
- SRA a=0x81 amt=3 -> three cycles fs=010 with alu_a sequence 0x81, 0xC0, 0xE0; res_data=0xF0, res_carry=0; cmd_ready=0 throughout.
- SLL a=0x5A amt=0 -> no cycle with fs!=000; res_valid the cycle after accept; res_data=0x5A, res_carry=0.
- Backpressure: OR a=0x0F b=0x30 with res_ready=0 for 5 cycles while cmd_valid=1 with op=ADD -> res_data=0x3F held stable, cmd_ready=0, second command not latched until after res handshake.
- Illegal op=111 a=0xFF -> res_valid after accept, res_data=0x00, res_err=1; next legal command clears res_err.
- rst_n low during SRL amt=7 cycle 3 -> fs=000, alu_a=0, res_valid=0 immediately (no clock); after release cmd_ready=1 and a new ADD 0x01+0x01 returns 0x02.
